rs_syndrome_stream: RTL and testbench

Parametrised streaming syndrome unit for the RS decoder family over GF(2^8). It replaces the fixed RS(132,120) syndrome front end with one block that covers any code length and parity count. It checks frame framing, computes all NPAR syndromes by Horner evaluation as symbols arrive, and hands the result to the key-equation stage through a one-deep valid/ready output register.

---
 rtl/rs_syndrome_stream_if.sv | 34 +++
 rtl/rs_syndrome_stream.sv | 167 ++++++++++++++++
 tb/tb_rs_syndrome_stream.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_syndrome_stream_if.sv
// Stream bundle for rs_syndrome_stream.
// The master drives the symbol stream and synd_rdy.
// The slave (the syndrome unit) drives the result, the status pulses and the debug state.
//
// Handshake semantics:
//   Input side: a symbol is consumed in every cycle with din_val = 1. There is no backpressure.
//   Output side: a result transfers on a rising edge where synd_val & synd_rdy.
//   synd and synd_zero stay stable while synd_val = 1 and no transfer occurs.
interface rs_syndrome_stream_if #(
  parameter int NPAR = 12
);
  logic              din_val;
  logic              din_sop;
  logic              din_eop;
  logic [7:0]        din;
  logic              synd_val;
  logic              synd_rdy;
  logic [8*NPAR-1:0] synd;
  logic              synd_zero;
  logic              frame_err;
  logic              ovf;
  logic [15:0]       synd_err_cnt;
  logic              fsm_state;   // 0 = IDLE, 1 = ACC

  modport master (
    output din_val, din_sop, din_eop, din, synd_rdy,
    input  synd_val, synd, synd_zero, frame_err, ovf, synd_err_cnt, fsm_state
  );

  modport slave (
    input  din_val, din_sop, din_eop, din, synd_rdy,
    output synd_val, synd, synd_zero, frame_err, ovf, synd_err_cnt, fsm_state
  );
endinterface

// File: rtl/rs_syndrome_stream.sv
// Streaming RS syndrome unit over GF(2^8).
// It checks frame framing and evaluates all NPAR syndromes by Horner's rule.
// Results are handed off through a one-deep valid/ready register.
//
// Optional feature: define RS_SYND_ERRCNT_EN to enable a saturating count of
// frames with nonzero syndromes. Without the macro, synd_err_cnt is tied to zero.
module rs_syndrome_stream #(
  parameter int         N    = 132,
  parameter int         NPAR = 12,
  parameter int         FCR  = 0,
  parameter logic [7:0] PRIM = 8'h1D
) (
  input  logic                 clk,
  input  logic                 rst,
  rs_syndrome_stream_if.slave  s
);

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} state_t;

  // GF(2^8) multiply, modulo x^8 + PRIM.
  // The second operand is always a constant root, so this reduces to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? PRIM : 8'h00);
    end
    return p;
  endfunction

  // alpha^e, computed at elaboration time. The exponent is reduced mod 255.
  function automatic logic [7:0] alpha_pow(input int e);
    logic [7:0] x;
    x = 8'h01;
    for (int k = 0; k < (e % 255); k++)
      x = {x[6:0], 1'b0} ^ (x[7] ? PRIM : 8'h00);
    return x;
  endfunction

  state_t            state;
  logic [7:0]        cnt;
  logic [8*NPAR-1:0] acc;
  logic [8*NPAR-1:0] acc_next;
  logic [8*NPAR-1:0] din_rep;
  logic              frame_err_q;
  logic              synd_val_q;
  logic [8*NPAR-1:0] synd_q;
  logic              synd_zero_q;
  logic              ovf_q;

  // One Horner step per syndrome lane: acc_i * alpha^(FCR+i) + din.
  for (genvar i = 0; i < NPAR; i++) begin : g_lane
    localparam logic [7:0] ROOT = alpha_pow(FCR + i);
    assign acc_next[8*i +: 8] = gf_mul(acc[8*i +: 8], ROOT) ^ s.din;
    assign din_rep[8*i +: 8]  = s.din;
  end

  logic [8:0] cnt_inc;
  logic       last_sym;
  logic       complete;
  logic       load;

  assign cnt_inc  = {1'b0, cnt} + 9'd1;
  assign last_sym = (cnt_inc == 9'(N));

  // Completion outranks the sop restart when both land on the same symbol.
  assign complete = s.din_val && (state == ACC) && s.din_eop && last_sym;
  assign load     = complete && (!synd_val_q || s.synd_rdy);

  // Framing FSM and syndrome accumulators.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      acc         <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (s.din_val) begin
        case (state)
          IDLE: begin
            if (s.din_sop) begin
              acc <= din_rep;
              cnt <= 8'd1;
              // A frame of length 1 can never match N (N >= 2).
              if (s.din_eop) begin
                frame_err_q <= 1'b1;
                state       <= IDLE;
              end else begin
                state <= ACC;
              end
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          ACC: begin
            if (complete) begin
              acc   <= acc_next;
              cnt   <= 8'd0;
              state <= IDLE;
            end else if (s.din_sop) begin
              frame_err_q <= 1'b1;
              acc         <= din_rep;
              cnt         <= 8'd1;
              state       <= s.din_eop ? IDLE : ACC;
            end else if (s.din_eop || last_sym) begin
              frame_err_q <= 1'b1;
              cnt         <= 8'd0;
              state       <= IDLE;
            end else begin
              acc <= acc_next;
              cnt <= cnt_inc[7:0];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // One-deep output register. A completed frame that finds it occupied is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      synd_val_q  <= 1'b0;
      synd_q      <= '0;
      synd_zero_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      ovf_q <= complete && !load;
      if (load) begin
        synd_val_q  <= 1'b1;
        synd_q      <= acc_next;
        synd_zero_q <= (acc_next == '0);
      end else if (synd_val_q && s.synd_rdy) begin
        synd_val_q <= 1'b0;
      end
    end
  end

`ifdef RS_SYND_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of loaded results that flag an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 16'h0000;
    end else if (load && (acc_next != '0) && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign s.synd_err_cnt = err_cnt_q;
`else
  assign s.synd_err_cnt = 16'h0000;
`endif

  assign s.synd_val  = synd_val_q;
  assign s.synd      = synd_q;
  assign s.synd_zero = synd_zero_q;
  assign s.frame_err = frame_err_q;
  assign s.ovf       = ovf_q;
  assign s.fsm_state = state;

endmodule

// File: tb/tb_rs_syndrome_stream.sv
// Self-checking bench for rs_syndrome_stream (N=132, NPAR=12, FCR=0, PRIM=0x1D).
// The reference model evaluates each syndrome directly from the received
// polynomial, using log/antilog tables.
module tb_rs_syndrome_stream;
  localparam int         N    = 132;
  localparam int         NPAR = 12;
  localparam int         FCR  = 0;
  localparam logic [7:0] PRIM = 8'h1D;
  localparam int         SW   = 8 * NPAR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_syndrome_stream_if #(.NPAR(NPAR)) bus ();

  rs_syndrome_stream #(.N(N), .NPAR(NPAR), .FCR(FCR), .PRIM(PRIM)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] mon_e;
  int          fe_cnt = 0, ovf_cnt = 0;
  int          exp_fe = 0, exp_ovf = 0;
  int          exp_err_cnt = 0;
  logic [7:0]  fbuf[0:255];
  logic [7:0]  exp_t[0:254];
  int          log_t[0:255];
  bit          gap_en = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // S_i = sum_j r_j * alpha^((FCR+i)*(n-1-j)), where r_0 is the highest-degree coefficient.
  function automatic logic [SW-1:0] model_synd(input int n);
    logic [SW-1:0] r;
    logic [7:0]    acc;
    r = '0;
    for (int i = 0; i < NPAR; i++) begin
      acc = 8'h00;
      for (int j = 0; j < n; j++)
        if (fbuf[j] != 8'h00)
          acc = acc ^ exp_t[(log_t[fbuf[j]] + ((FCR + i) * (n - 1 - j)) % 255) % 255];
      r[8*i +: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [15:0] exp_cnt_val();
`ifdef RS_SYND_ERRCNT_EN
    return (exp_err_cnt > 65535) ? 16'hFFFF : 16'(exp_err_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic expect_frame(input int n);
    logic [SW-1:0] e;
    e = model_synd(n);
    exp_q.push_back(e);
    if (e != '0) exp_err_cnt++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic sp, input logic ep, input logic [7:0] d);
    @(posedge clk);
    #1;
    bus.din_val = v;
    bus.din_sop = sp;
    bus.din_eop = ep;
    bus.din     = d;
  endtask

  task automatic idle(input int k);
    repeat (k) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic fill(input int n, input bit rnd);
    for (int j = 0; j < n; j++) fbuf[j] = rnd ? 8'($urandom_range(255)) : 8'h00;
  endtask

  task automatic send_syms(input int n, input bit with_sop, input bit with_eop);
    for (int j = 0; j < n; j++) begin
      if (gap_en && j > 0 && $urandom_range(3) == 0) drive(1'b0, 1'b0, 1'b0, 8'($urandom_range(255)));
      drive(1'b1, with_sop && (j == 0), with_eop && (j == n - 1), fbuf[j]);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_err) fe_cnt++;
      if (bus.ovf) ovf_cnt++;
      if (bus.synd_val && bus.synd_rdy) begin
        if (exp_q.size() == 0) begin
          check("unexpected_synd", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("synd", bus.synd, mon_e);
          check("synd_zero", bus.synd_zero, (mon_e == '0));
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    begin
      int x;
      x = 1;
      for (int k = 0; k < 255; k++) begin
        exp_t[k] = x[7:0];
        log_t[x] = k;
        x = x << 1;
        if ((x & 256) != 0) x = x ^ (256 | int'(PRIM));
      end
      log_t[0] = 0;
    end

    bus.din_val = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0; bus.din = 8'h00;
    bus.synd_rdy = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_synd_val", bus.synd_val, 0);
    check("rst_synd", bus.synd, 0);
    check("rst_synd_zero", bus.synd_zero, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_err_cnt", bus.synd_err_cnt, 0);
    check("rst_fsm", bus.fsm_state, 0);

    // All-zero frame: result appears one cycle after eop.
    fill(N, 1'b0);
    expect_frame(N);
    send_syms(N, 1'b1, 1'b1);
    idle(1);
    @(negedge clk);
    check("zero_latency", bus.synd_val, 1);
    check("zero_err_cnt", bus.synd_err_cnt, exp_cnt_val());

    // A single 0x01 in the constant term gives S_i = 1 for all i.
    fill(N, 1'b0);
    fbuf[N-1] = 8'h01;
    expect_frame(N);
    send_syms(N, 1'b1, 1'b1);
    idle(1);
    @(negedge clk);
    check("ones_val", bus.synd_val, 1);
    check("ones_synd", bus.synd, {NPAR{8'h01}});
    check("ones_err_cnt", bus.synd_err_cnt, exp_cnt_val());

    // Early eop on symbol 100, then a clean frame.
    fill(N, 1'b1);
    send_syms(100, 1'b1, 1'b1);
    exp_fe++;
    idle(1);
    @(negedge clk);
    check("short_frame_err", bus.frame_err, 1);
    check("short_no_val", bus.synd_val, 0);
    @(negedge clk);
    check("short_pulse_once", bus.frame_err, 0);
    fill(N, 1'b1);
    expect_frame(N);
    send_syms(N, 1'b1, 1'b1);
    idle(2);

    // Two back-to-back frames with the consumer stalled.
    bus.synd_rdy = 1'b0;
    fill(N, 1'b1);
    expect_frame(N);
    send_syms(N, 1'b1, 1'b1);
    fill(N, 1'b1);
    send_syms(N, 1'b1, 1'b1);
    exp_ovf++;
    idle(1);
    @(negedge clk);
    check("ovf_pulse", bus.ovf, 1);
    check("ovf_held_val", bus.synd_val, 1);
    check("ovf_held_synd", bus.synd, exp_q[0]);
    @(posedge clk);
    #1 bus.synd_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drain_val", bus.synd_val, 0);

    // sop again at symbol 50 restarts the frame.
    fill(49, 1'b1);
    send_syms(49, 1'b1, 1'b0);
    exp_fe++;
    fill(N, 1'b1);
    expect_frame(N);
    send_syms(N, 1'b1, 1'b1);
    idle(2);

    // Reset at symbol 60 abandons everything silently.
    fill(59, 1'b1);
    send_syms(59, 1'b1, 1'b0);
    @(negedge clk);
    check("mid_fsm_acc", bus.fsm_state, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.din_val = 1'b0; bus.din_sop = 1'b0; bus.din_eop = 1'b0;
    exp_err_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_err_cnt", bus.synd_err_cnt, 0);
    check("post_rst_fsm", bus.fsm_state, 0);
    fill(N, 1'b1);
    expect_frame(N);
    send_syms(N, 1'b1, 1'b1);
    idle(2);
    check("post_rst_frame_err_cnt", fe_cnt, exp_fe);
    check("post_rst_ovf_cnt", ovf_cnt, exp_ovf);

    // Random frames with idle gaps, back-to-back sop, and stray symbols.
    gap_en = 1'b1;
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(2) == 0) begin
        drive(1'b1, 1'b0, 1'b0, 8'($urandom_range(255)));
        exp_fe++;
      end
      fill(N, ($urandom_range(4) != 0));
      expect_frame(N);
      send_syms(N, 1'b1, 1'b1);
    end
    gap_en = 1'b0;
    idle(4);

    check("final_frame_err_cnt", fe_cnt, exp_fe);
    check("final_ovf_cnt", ovf_cnt, exp_ovf);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_err_cnt", bus.synd_err_cnt, exp_cnt_val());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
